// File: rtl/and_gate_unit_pkg.sv
// and_gate_pkg: shared constants for the and_gate_unit slice.
//   COMBO_00..COMBO_11 : statistics index for the input pair {a[0],b[0]}
//   DEF_WIDTH, DEF_CNT_W : default operand and counter widths
package and_gate_pkg;
    localparam int COMBO_00  = 0;
    localparam int COMBO_01  = 1;
    localparam int COMBO_10  = 2;
    localparam int COMBO_11  = 3;
    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/and_gate_unit_sat_counter.sv
// sat_counter: CNT_W-bit up counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count up by one this edge (ignored once saturated)
//   clr        : synchronous clear, wins over inc
//   q          : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + 1'b1;
endmodule

// File: rtl/and_gate_unit.sv
// and_gate_unit: bitwise AND cell with a registered, valid-tracked copy.
//   clk, rst_n      : clock, asynchronous active-low reset
//   a, b, in_valid  : operands and their qualifier
//   y               : combinational a & b
//   y_q, out_valid  : a & b registered one cycle after a valid input
//   all_ones        : every bit of y_q set while out_valid
//   stats_clr       : clears the statistics counters
//   cnt_00..cnt_11  : per {a[0],b[0]} saturating counts of valid inputs,
//                     present only when AND_STATS_EN is defined
module and_gate_unit
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_ones,
    input  logic             stats_clr
`ifdef AND_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt_00,
    output logic [CNT_W-1:0] cnt_01,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_11
`endif
);
    assign y        = a & b;
    assign all_ones = out_valid & (&y_q);

    // y_q keeps its last result when idle; only out_valid tracks freshness
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            y_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                y_q <= a & b;
        end

`ifdef AND_STATS_EN
    logic [1:0]       combo;
    logic [CNT_W-1:0] cnt [4];

    assign combo = {a[0], b[0]};

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (in_valid && combo == 2'(i)),
            .clr  (stats_clr),
            .q    (cnt[i])
        );
    end

    assign cnt_00 = cnt[COMBO_00];
    assign cnt_01 = cnt[COMBO_01];
    assign cnt_10 = cnt[COMBO_10];
    assign cnt_11 = cnt[COMBO_11];
`else
    logic unused_stats;
    assign unused_stats = stats_clr ^ (CNT_W > 0);
`endif
endmodule

// File: tb/tb_and_gate_unit.sv
// tb_and_gate_unit: directed plus random checks of and_gate_unit at WIDTH 1 and 8.
module tb_and_gate_unit;
    localparam int TB_CNT_W = 2;
    localparam int SAT = (1 << TB_CNT_W) - 1;

    logic clk = 0, rst_n = 0, in_valid = 0, stats_clr = 0;
    logic       a1 = 0, b1 = 0, y1, yq1, ov1, ao1;
    logic [7:0] a8 = 0, b8 = 0, y8, yq8;
    logic       ov8, ao8;
`ifdef AND_STATS_EN
    logic [TB_CNT_W-1:0] c00, c01, c10, c11;
    logic [15:0]         d00, d01, d10, d11;
`endif

    int checks = 0, errors = 0;
    logic [7:0] e1 = 0, e8 = 0;
    logic       ov = 0;
    int         cnt [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    and_gate_unit #(.WIDTH(1), .CNT_W(TB_CNT_W)) d1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
        .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(ao1), .stats_clr(stats_clr)
`ifdef AND_STATS_EN
        , .cnt_00(c00), .cnt_01(c01), .cnt_10(c10), .cnt_11(c11)
`endif
    );

    and_gate_unit #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(in_valid),
        .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(ao8), .stats_clr(stats_clr)
`ifdef AND_STATS_EN
        , .cnt_00(d00), .cnt_01(d01), .cnt_10(d10), .cnt_11(d11)
`endif
    );

    // bitwise AND rebuilt from per-bit products
    function automatic logic [7:0] ref_and(input logic [7:0] x, input logic [7:0] z);
        int r = 0;
        for (int i = 0; i < 8; i++)
            r += (((x >> i) % 2) * ((z >> i) % 2)) << i;
        return 8'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs();
        chk("yq1", 32'(yq1), 32'(e1[0]));
        chk("ov1", 32'(ov1), 32'(ov));
        chk("ao1", 32'(ao1), 32'(ov && e1[0]));
        chk("yq8", 32'(yq8), 32'(e8));
        chk("ov8", 32'(ov8), 32'(ov));
        chk("ao8", 32'(ao8), 32'(ov && e8 == 8'hFF));
`ifdef AND_STATS_EN
        chk("c00", 32'(c00), 32'(cnt[0]));
        chk("c01", 32'(c01), 32'(cnt[1]));
        chk("c10", 32'(c10), 32'(cnt[2]));
        chk("c11", 32'(c11), 32'(cnt[3]));
`endif
    endtask

    task automatic cycle(input logic ai, input logic bi, input logic [7:0] ai8,
                         input logic [7:0] bi8, input logic v, input logic clr);
        @(negedge clk);
        a1 = ai; b1 = bi; a8 = ai8; b8 = bi8; in_valid = v; stats_clr = clr;
        #1;
        chk("y1", 32'(y1), 32'(ref_and(8'(ai), 8'(bi))));
        chk("y8", 32'(y8), 32'(ref_and(ai8, bi8)));
        @(posedge clk);
        if (clr)
            cnt = '{0, 0, 0, 0};
        else if (v && cnt[ai * 2 + bi] < SAT)
            cnt[ai * 2 + bi]++;
        if (v) begin
            e1 = ref_and(8'(ai), 8'(bi));
            e8 = ref_and(ai8, bi8);
        end
        ov = v;
        #1;
        chk_regs();
    endtask

    initial begin
        #1;
        chk_regs();
        @(negedge clk);
        rst_n = 1;
        // truth table, idle then valid
        for (int i = 0; i < 4; i++) cycle(1'(i >> 1), 1'(i), 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'(i >> 1), 1'(i), 8'h00, 8'h00, 1, 0);
        cycle(0, 0, 8'hF0, 8'h3C, 1, 0);
        cycle(1, 1, 8'hFF, 8'hFF, 1, 0);
        cycle(1, 0, 8'hA5, 8'h0F, 1, 0);
        cycle(0, 0, 8'h00, 8'h00, 0, 0);
        cycle(0, 0, 8'hFF, 8'hFF, 0, 0);
        // X handling: 0 dominates, otherwise X
        @(negedge clk);
        a1 = 1'bx; b1 = 0; a8 = 8'hxx; b8 = 8'h0F; in_valid = 0;
        #1;
        chk("x_and_0", 32'(y1), 32'(1'b0));
        chk("x_and_8", 32'(y8), {24'h0, 8'h0x});
        b1 = 1;
        #1;
        chk("x_and_1", {31'h0, y1}, {31'h0, 1'bx});
        // counters saturate, then clear beats increment
        for (int i = 0; i < 5; i++) cycle(1, 1, 8'hFF, 8'hFF, 1, 0);
        cycle(0, 0, 8'h00, 8'h00, 1, 1);
        // random traffic
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        // mid-cycle async reset, no clock needed
        cycle(1, 1, 8'hFF, 8'hFF, 1, 0);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        e1 = 0; e8 = 0; ov = 0; cnt = '{0, 0, 0, 0};
        chk_regs();
        @(negedge clk);
        rst_n = 1;
        cycle(1, 1, 8'h3C, 8'hF0, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/and_gate_unit.md
Name: and_gate_unit

Overview:
- Parameterised bitwise AND cell; output `y` is purely combinational and equals `a & b`.
- Adds a one-cycle registered copy with valid tracking, for timing-closed consumers.
- Optional per-combination stimulus statistics for bring-up and coverage.
- Sits as a leaf primitive under datapath/control logic; no downstream backpressure.

Parameters:
- WIDTH, 1, bit width of operands and result.
- CNT_W, 16, width of each statistics counter (used only when AND_STATS_EN is defined).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for the registered path and statistics.
- y  output  WIDTH  combinational a & b.
- y_q  output  WIDTH  registered a & b.
- out_valid  output  1  y_q holds a valid result.
- all_ones  output  1  reduction AND of y_q, gated by out_valid.
- stats_clr  input  1  synchronous clear of statistics (ignored without AND_STATS_EN).
- cnt_00, cnt_01, cnt_10, cnt_11  output  CNT_W each  statistics counters (present only with AND_STATS_EN).

Behaviour:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- Combinational output: `y = a & b` bitwise.
  - Independent of clk, rst_n and in_valid.
  - Settles within the same delta cycle as input changes.
  - For WIDTH=1: 00→0, 01→0, 10→0, 11→1.
- Reset: while rst_n=0, `y_q=0`, `out_valid=0`, `all_ones=0`, and all counters are 0. Assertion is immediate; release is synchronous to the next clk edge.
- Registered path, one cycle latency, updated on each rising clk edge:
  - if in_valid=1: `y_q <= a & b` and `out_valid <= 1`.
  - if in_valid=0: `y_q` holds its value and `out_valid <= 0`.
- `all_ones = out_valid & (&y_q)`; combinational from registers.
- No handshake stalls: every valid input is accepted. Back-to-back valids produce back-to-back results.
- Reset asserted mid-stream: the in-flight result is discarded and out_valid drops immediately.
- X on a or b propagates per standard 4-state AND: 0 dominates, otherwise X.

Optional Feature:
- Macro: AND_STATS_EN.
- When defined:
  - Four counters track bit-0 input combinations {a[0],b[0]} = 00, 01, 10, 11.
  - The matching counter increments on each clk edge with in_valid=1.
  - Counters saturate at all-ones and do not wrap.
  - stats_clr=1 zeroes all four on that edge; clear takes priority over a simultaneous increment.
  - Async reset zeroes all counters.
- When undefined: counter logic and cnt_* ports are absent, stats_clr is accepted and unused, and all other behaviour is identical.

Decomposition:
- Shared package `and_gate_pkg` holds:
  - combo index localparams COMBO_00..COMBO_11 (0..3);
  - default widths DEF_WIDTH=1 and DEF_CNT_W=16.
- One natural sub-module: `sat_counter`, a CNT_W saturating counter with inc, clr and async active-low reset. It is instantiated four times under AND_STATS_EN.
- The core AND and register stay in the top.

Test Plan:
- WIDTH=1, reset released, apply a,b = 00, 01, 10, 11, holding each 10 time units → y = 0, 0, 0, 1, each within the same timestep.
- Same sequence with in_valid=1 each cycle → y_q/out_valid follow one cycle later. all_ones=1 only on the cycle after 11.
- WIDTH=8: a=8'hF0, b=8'h3C, in_valid=1 → y=8'h30 immediately; y_q=8'h30 and out_valid=1 next edge; all_ones=0. Then a=b=8'hFF → all_ones=1.
- in_valid pulsed 1 then held 0 → out_valid drops after one cycle and y_q holds its last value. Assert rst_n=0 mid-cycle → y_q=0 and out_valid=0 immediately, without a clock.
- AND_STATS_EN, CNT_W=2:
  - drive 11 valid for 5 cycles → cnt_11=3 (saturated); other counters stay 0.
  - assert stats_clr alongside a valid 00 → all counters=0, including cnt_00.
- AND_STATS_EN undefined → design elaborates without cnt_* ports, and the four-case truth-table test still passes.
